// File: rtl/div_seq_pkg.sv
// Shared types for the sequential restoring divider.
// FSM state encodings and the iteration-counter width helper.
package div_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step:
// shift in the next dividend bit, trial-subtract, restore on borrow.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dmsb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             qbit
);

  logic [WIDTH-1:0] sh;
  logic [WIDTH:0]   trial;
  logic             unused_msb;

  // rem_in < 2^(WIDTH-1) whenever a shift happens, so its msb carries nothing
  assign unused_msb = rem_in[WIDTH-1];
  assign sh         = {rem_in[WIDTH-2:0], dmsb};
  assign trial      = {1'b0, sh} - {1'b0, divisor};
  assign qbit       = ~trial[WIDTH];
  assign rem_out    = qbit ? trial[WIDTH-1:0] : sh;

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Optional DIV_DZ_FLAG_EN adds a registered divide-by-zero flag (dz).
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
`ifdef DIV_DZ_FLAG_EN
  ,
  output logic             dz
`endif
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] rem_nx;
  logic             qbit;
  logic             last;
  logic             accept;

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign accept = start & ~busy;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in (rem_q),
    .dmsb   (dvd_q[WIDTH-1]),
    .divisor(dvs_q),
    .rem_out(rem_nx),
    .qbit   (qbit)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // the dividend register doubles as the quotient shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      q       <= '0;
      r       <= '0;
`ifdef DIV_DZ_FLAG_EN
      dz      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        dvd_q <= a;
        dvs_q <= b;
        rem_q <= '0;
        cnt_q <= '0;
      end else if (busy) begin
        dvd_q <= {dvd_q[WIDTH-2:0], qbit};
        rem_q <= rem_nx;
        cnt_q <= cnt_q + CW'(1);
        if (last) begin
          q  <= {dvd_q[WIDTH-2:0], qbit};
          r  <= rem_nx;
`ifdef DIV_DZ_FLAG_EN
          dz <= (dvs_q == '0);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq at WIDTH=4.
// Covers latency, b==0, ignored start, back-to-back and mid-run reset.
module tb_div_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a, b, q, r;
  logic       busy, done;
`ifdef DIV_DZ_FLAG_EN
  logic       dz;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .q    (q),
    .r    (r)
`ifdef DIV_DZ_FLAG_EN
    ,
    .dz   (dz)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // starts and ends on a negedge
  task automatic run_op(input string tag, input int av, input int bv,
                        input int eq, input int er);
    int n = 0;
    int t = 0;
    a     = av[3:0];
    b     = bv[3:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && t < 20) begin
      t++;
      if (busy) n++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_q"}, int'(q), eq);
    chk({tag, "_r"}, int'(r), er);
`ifdef DIV_DZ_FLAG_EN
    chk({tag, "_dz"}, int'(dz), (bv == 0) ? 1 : 0);
`endif
    @(negedge clk);
    chk({tag, "_pulse"}, int'(done), 0);
  endtask

  initial begin
    int n;
    int t;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_q", int'(q), 0);
    chk("rst_r", int'(r), 0);
`ifdef DIV_DZ_FLAG_EN
    chk("rst_dz", int'(dz), 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_op("t1_13_4", 13, 4, 3, 1);
    run_op("t2_15_15", 15, 15, 1, 0);
    run_op("t2_2_9", 2, 9, 0, 2);

    // start during RUN is ignored; q/r hold the previous result meanwhile
    a = 4'd13; b = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4_busy", int'(busy), 1);
    @(negedge clk);
    chk("t4_hold_q", int'(q), 0);
    chk("t4_hold_r", int'(r), 2);
    a = 4'd9; b = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!done && t < 20) begin
      t++;
      @(negedge clk);
    end
    chk("t4_done", int'(done), 1);
    chk("t4_q", int'(q), 3);
    chk("t4_r", int'(r), 1);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      n += int'(done) + int'(busy);
    end
    chk("t4_single", n, 0);

    run_op("t3_7_0", 7, 0, 15, 7);

    for (int i = 0; i < 16; i++)
      for (int j = 1; j < 16; j++)
        run_op("sweep", i, j, i / j, i % j);

    // start held high: accepted on each done cycle, done every 5 cycles
    a = 4'd13; b = 4'd4; start = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_busy4", int'(busy), 1);
    @(negedge clk);
    chk("t5_d1", int'(done), 1);
    chk("t5_q1", int'(q), 3);
    chk("t5_r1", int'(r), 1);
    a = 4'd15; b = 4'd15;
    repeat (4) begin
      @(negedge clk);
      chk("t5_gap1", int'(done), 0);
    end
    @(negedge clk);
    chk("t5_d2", int'(done), 1);
    chk("t5_q2", int'(q), 1);
    chk("t5_r2", int'(r), 0);
    a = 4'd2; b = 4'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_gap2", int'(done), 0);
    end
    @(negedge clk);
    chk("t5_d3", int'(done), 1);
    chk("t5_q3", int'(q), 0);
    chk("t5_r3", int'(r), 2);
    @(negedge clk);
    chk("t5_idle", int'(busy), 0);

    run_op("t6_pre", 13, 4, 3, 1);

    // reset during RUN aborts with no trailing done
    a = 4'd14; b = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("t6_run", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy", int'(busy), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_q", int'(q), 0);
    chk("t6_r", int'(r), 0);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      n += int'(done);
    end
    chk("t6_nodone", n, 0);
    run_op("t6_after", 14, 3, 4, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
